countdown_timer: RTL and testbench
==================================

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter width, default 32, bitwidth of Count, In and the reload register.
REQ-002 SHALL have parameter autoreload, default 0; when 1, the counter reloads after expiry.
REQ-003 SHALL have port Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port Load  input  1  loads In into Count and the reload register.
REQ-006 SHALL have port In  input  width  load value.
REQ-007 SHALL have port Enable  input  1  permits decrement in RUN.
REQ-008 SHALL have port Count  output  width  current count, registered.
REQ-009 SHALL have port Busy  output  1  high while in RUN.
REQ-010 SHALL have port Expire  output  1  one-cycle pulse, high while in DONE.
REQ-011 SHALL have port Zero  output  1  combinational (Count == 0).

Function
REQ-012 SHALL implement a three-state FSM: IDLE, RUN, DONE; Busy = (state == RUN); Expire = (state == DONE).
REQ-013 Load SHALL have priority over all other activity in every state; in the next cycle, Count = In, reload = In, and the prescaler (if present) = 0.
REQ-014 Load with In != 0 SHALL enter RUN; Load with In == 0 SHALL enter IDLE with no Expire pulse.
REQ-015 In RUN, an Enable cycle with a tick (REQ-026/027) SHALL decrement Count by 1.
REQ-016 In RUN, a decrement from Count == 1 SHALL give Count = 0 and next state DONE.
REQ-017 Expire SHALL therefore be high in the same cycle that Count first reads 0.
REQ-018 In RUN with Enable low, Count and state SHALL hold.
REQ-019 DONE SHALL last exactly one cycle, regardless of Enable.
REQ-020 From DONE with autoreload = 1 and reload != 0, the next cycle SHALL have Count = reload and state RUN; otherwise the next state SHALL be IDLE with Count = 0.
REQ-021 In IDLE, Enable SHALL have no effect: no underflow, and Count saturates at 0.
REQ-022 Count SHALL never wrap from 0 to all-ones under any input sequence.
REQ-023 Load asserted during DONE SHALL override the reload, and Expire SHALL still be high for that DONE cycle.

Reset
REQ-024 With Reset low at a rising Clock edge, the next state SHALL be IDLE, with Count = 0, reload = 0, Expire = 0, Busy = 0 and prescaler = 0; Reset overrides Load.
REQ-025 Reset asserted mid-RUN SHALL abort the count with no Expire pulse, and the timer SHALL stay in IDLE until the next Load.

Configuration
REQ-026 With macro COUNTDOWN_TIMER_PRESCALE_EN defined:
- adds parameter prescale, default 4 (must be >= 2);
- adds an internal counter of clog2(prescale) bits that advances only on Enable cycles in RUN;
- a tick occurs on the Enable cycle where this counter equals prescale-1, and the counter then returns to 0;
- the counter clears on Load, Reset and exit from RUN.
REQ-027 Without COUNTDOWN_TIMER_PRESCALE_EN, every Enable cycle in RUN SHALL be a tick, and no prescale logic or parameter SHALL exist.

Verification
REQ-028 Reset low 1 cycle, then Load In=3, Enable held high (no prescale) -> Count 3,2,1,0; Busy high for 3 cycles; Expire high exactly in the Count=0 cycle; then IDLE with Count 0.
REQ-029 autoreload=1, Load In=2, Enable high -> Count 2,1,0,2,1,0...; Expire pulses every 3rd cycle; Busy low only in DONE cycles.
REQ-030 Load In=5, Enable toggled 1,0,1,0 -> Count 5,4,4,3,3; state RUN throughout.
REQ-031 In IDLE with Count 0, Enable high for 10 cycles -> Count stays 0; Expire never asserts; Zero=1.
REQ-032 Load In=4; after 2 decrements, Reset low -> next cycle Count 0, IDLE, no Expire; Load In=0 -> IDLE, Expire 0.
REQ-033 COUNTDOWN_TIMER_PRESCALE_EN defined, prescale=4, Load In=2, Enable high -> Count changes every 4th cycle; Expire on cycle 8 after Load.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable down-counter with IDLE/RUN/DONE control, one-cycle Expire pulse and optional autoreload.
// Optional tick prescaler is built only when COUNTDOWN_TIMER_PRESCALE_EN is defined.
module countdown_timer #(
  parameter int unsigned width      = 32,
  parameter int unsigned autoreload = 0
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
  ,
  parameter int unsigned prescale   = 4
`endif
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Load,
  input  logic [width-1:0] In,
  input  logic             Enable,
  output logic [width-1:0] Count,
  output logic             Busy,
  output logic             Expire,
  output logic             Zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [width-1:0]   count_nx;
  logic [width-1:0]   reload;
  logic [width-1:0]   reload_nx;
  logic               busy_nx;
  logic               expire_nx;
  logic               tick_c;

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
  localparam int unsigned PW = (prescale > 1) ? $clog2(prescale) : 1;
  logic [PW-1:0] pre;
  logic [PW-1:0] pre_nx;
`endif

  // Next-state, next-count and reload selection; Load wins over everything.
  always_comb begin
    state_nx  = state;
    count_nx  = Count;
    reload_nx = reload;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    pre_nx    = pre;
    tick_c    = Enable && (pre == PW'(prescale - 1));
`else
    tick_c    = Enable;
`endif
    if (Load) begin
      count_nx  = In;
      reload_nx = In;
      state_nx  = (In != '0) ? RUN : IDLE;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
      pre_nx    = '0;
`endif
    end else begin
      case (state)
        RUN: begin
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
          if (Enable) pre_nx = tick_c ? '0 : pre + PW'(1);
`endif
          if (tick_c) begin
            // Count <= 1 also catches a stray zero so the counter never wraps.
            if (Count <= width'(1)) begin
              count_nx = '0;
              state_nx = DONE;
            end else begin
              count_nx = Count - width'(1);
            end
          end
        end
        DONE: begin
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
          pre_nx = '0;
`endif
          if ((autoreload != 0) && (reload != '0)) begin
            count_nx = reload;
            state_nx = RUN;
          end else begin
            count_nx = '0;
            state_nx = IDLE;
          end
        end
        default: begin
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
          pre_nx   = '0;
`endif
          count_nx = '0;
          state_nx = IDLE;
        end
      endcase
    end
    busy_nx   = (state_nx == RUN);
    expire_nx = (state_nx == DONE);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state  <= IDLE;
      Count  <= '0;
      reload <= '0;
      Busy   <= 1'b0;
      Expire <= 1'b0;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
      pre    <= '0;
`endif
    end else begin
      state  <= state_nx;
      Count  <= count_nx;
      reload <= reload_nx;
      Busy   <= busy_nx;
      Expire <= expire_nx;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
      pre    <= pre_nx;
`endif
    end
  end

  assign Zero = (Count == '0);

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (autoreload 0 and 1) checked every cycle against a
// behavioural model, plus directed vectors with literal expectations.
module tb_countdown_timer;

  localparam int unsigned W = 8;
  localparam int MIDLE = 0;
  localparam int MRUN  = 1;
  localparam int MDONE = 2;
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
  localparam int PS = 4;
`endif

  logic         Clock;
  logic         Reset;
  logic         Load;
  logic [W-1:0] In;
  logic         Enable;
  logic [W-1:0] count0, count1;
  logic         busy0, busy1, expire0, expire1, zero0, zero1;

  int vectors = 0;
  int miscompares = 0;
  bit checking = 1'b0;

  typedef struct {
    int mode;
    int count;
    int reload;
    int pre;
  } model_t;

  model_t m0, m1;

  countdown_timer #(
    .width(W), .autoreload(0)
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    , .prescale(PS)
`endif
  ) dut0 (
    .Clock(Clock), .Reset(Reset), .Load(Load), .In(In), .Enable(Enable),
    .Count(count0), .Busy(busy0), .Expire(expire0), .Zero(zero0)
  );

  countdown_timer #(
    .width(W), .autoreload(1)
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    , .prescale(PS)
`endif
  ) dut1 (
    .Clock(Clock), .Reset(Reset), .Load(Load), .In(In), .Enable(Enable),
    .Count(count1), .Busy(busy1), .Expire(expire1), .Zero(zero1)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Timer rules stated directly: what one clock edge does to a timer.
  function automatic model_t next_model(model_t s, int ar, bit r, bit l, int v, bit e);
    model_t n = s;
    bit tick;
    if (!r) begin
      n.mode = MIDLE; n.count = 0; n.reload = 0; n.pre = 0;
    end else if (l) begin
      n.count = v; n.reload = v; n.pre = 0;
      n.mode = (v != 0) ? MRUN : MIDLE;
    end else if (s.mode == MRUN) begin
      if (e) begin
`ifdef COUNTDOWN_TIMER_PRESCALE_EN
        tick = (s.pre == PS - 1);
        n.pre = tick ? 0 : s.pre + 1;
`else
        tick = 1'b1;
`endif
        if (tick) begin
          n.count = s.count - 1;
          if (n.count == 0) n.mode = MDONE;
        end
      end
    end else if (s.mode == MDONE) begin
      n.pre = 0;
      if (ar != 0 && s.reload != 0) begin
        n.count = s.reload; n.mode = MRUN;
      end else begin
        n.count = 0; n.mode = MIDLE;
      end
    end
    return n;
  endfunction

  always @(posedge Clock) begin
    m0 = next_model(m0, 0, Reset, Load, int'(In), Enable);
    m1 = next_model(m1, 1, Reset, Load, int'(In), Enable);
  end

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model comparison on every falling edge once reset has been applied.
  always @(negedge Clock) begin
    if (checking) begin
      chk("m0.count",  int'(count0),  m0.count);
      chk("m0.busy",   int'(busy0),   int'(m0.mode == MRUN));
      chk("m0.expire", int'(expire0), int'(m0.mode == MDONE));
      chk("m0.zero",   int'(zero0),   int'(m0.count == 0));
      chk("m1.count",  int'(count1),  m1.count);
      chk("m1.busy",   int'(busy1),   int'(m1.mode == MRUN));
      chk("m1.expire", int'(expire1), int'(m1.mode == MDONE));
      chk("m1.zero",   int'(zero1),   int'(m1.count == 0));
    end
  end

  task automatic drive(input bit r, input bit l, input int v, input bit e);
    #1;
    Reset = r; Load = l; In = W'(v); Enable = e;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    int exp_a0 [6];
    int exp_c1 [6];
    int exp_e1 [6];
    int exp_en [4];
    int exp_c30[4];
    Reset = 1'b0; Load = 1'b0; In = '0; Enable = 1'b0;
    m0 = '{MIDLE, 0, 0, 0};
    m1 = '{MIDLE, 0, 0, 0};
    @(negedge Clock);
    drive(0, 0, 0, 0);
    checking = 1'b1;
    chk("reset.count", int'(count0), 0);
    chk("reset.busy", int'(busy0), 0);
    chk("reset.expire", int'(expire0), 0);
    chk("reset.zero", int'(zero0), 1);

`ifdef COUNTDOWN_TIMER_PRESCALE_EN
    // Load 2 with prescale 4: one decrement per 4 enabled cycles, Expire on cycle 8.
    drive(1, 1, 2, 1);
    for (int c = 1; c <= 8; c++) begin
      drive(1, 0, 0, 1);
      chk("ps.count", int'(count0), (c < 4) ? 2 : (c < 8) ? 1 : 0);
      chk("ps.expire", int'(expire0), int'(c == 8));
    end
    drive(1, 0, 0, 1);
    chk("ps.idle", int'(busy0), 0);
`else
    // Load 3, Enable high: 3,2,1,0 then IDLE; autoreload instance restarts at 3.
    drive(1, 1, 3, 1);
    chk("r28.count3", int'(count0), 3);
    chk("r28.busy", int'(busy0), 1);
    drive(1, 0, 0, 1);
    chk("r28.count2", int'(count0), 2);
    drive(1, 0, 0, 1);
    chk("r28.count1", int'(count0), 1);
    drive(1, 0, 0, 1);
    chk("r28.count0", int'(count0), 0);
    chk("r28.expire", int'(expire0), 1);
    chk("r28.busy_done", int'(busy0), 0);
    drive(1, 0, 0, 1);
    chk("r28.idle_count", int'(count0), 0);
    chk("r28.idle_expire", int'(expire0), 0);
    chk("r28.reload_count", int'(count1), 3);
    chk("r28.reload_busy", int'(busy1), 1);

    // Load 2, Enable high: autoreload cycles 2,1,0; plain instance parks at 0.
    drive(1, 1, 2, 1);
    chk("r29.load", int'(count1), 2);
    exp_c1 = '{1, 0, 2, 1, 0, 2};
    exp_e1 = '{0, 1, 0, 0, 1, 0};
    exp_a0 = '{1, 0, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 1);
      chk("r29.count1", int'(count1), exp_c1[i]);
      chk("r29.expire1", int'(expire1), exp_e1[i]);
      chk("r29.busy1", int'(busy1), 1 - exp_e1[i]);
      chk("r29.count0", int'(count0), exp_a0[i]);
    end

    // Load 5, Enable 1,0,1,0: 5,4,4,3,3 and RUN throughout.
    drive(1, 1, 5, 1);
    chk("r30.load", int'(count0), 5);
    exp_en  = '{1, 0, 1, 0};
    exp_c30 = '{4, 4, 3, 3};
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 0, 1'(exp_en[i]));
      chk("r30.count", int'(count0), exp_c30[i]);
      chk("r30.busy", int'(busy0), 1);
    end

    // Load during DONE overrides reload; Expire still high in that DONE cycle.
    drive(1, 1, 1, 1);
    drive(1, 0, 0, 1);
    chk("r23.expire", int'(expire1), 1);
    drive(1, 1, 6, 0);
    chk("r23.count", int'(count1), 6);
    chk("r23.busy", int'(busy1), 1);
    chk("r23.no_expire", int'(expire1), 0);

    // Reset mid-run aborts silently; Reset beats Load; Load 0 stays idle.
    drive(1, 1, 4, 1);
    drive(1, 0, 0, 1);
    drive(1, 0, 0, 1);
    chk("r32.count2", int'(count0), 2);
    drive(0, 0, 0, 1);
    chk("r32.abort_count", int'(count0), 0);
    chk("r32.abort_busy", int'(busy0), 0);
    chk("r32.abort_expire", int'(expire0), 0);
    drive(0, 1, 9, 1);
    chk("r24.reset_over_load", int'(count0), 0);
    drive(1, 1, 0, 1);
    chk("r32.load0_busy", int'(busy0), 0);
    chk("r32.load0_expire", int'(expire0), 0);

    // Idle with Enable high: no underflow, Zero stays set.
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 0, 1);
      chk("r31.count", int'(count0), 0);
      chk("r31.zero", int'(zero0), 1);
      chk("r31.expire", int'(expire1), 0);
    end

    // Full-scale load decrements without overflow.
    drive(1, 1, 255, 1);
    chk("max.load", int'(count0), 255);
    drive(1, 0, 0, 1);
    chk("max.dec", int'(count0), 254);
`endif

    // Mixed stimulus checked by the model only.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 29) != 0), ($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 6)), ($urandom_range(0, 3) != 0));
    end

    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
